// File: rtl/cam_pkg.sv
// Shared constants and types for the parametrised CAM lookup table.
// Default geometry is 32 entries of 32 bits.
package cam_pkg;

  localparam int CAM_DEPTH  = 32;
  localparam int CAM_DATA_W = 32;
  localparam int CAM_IDX_W  = $clog2(CAM_DEPTH);

  typedef logic [CAM_IDX_W-1:0]  cam_idx_t;
  typedef logic [CAM_DATA_W-1:0] cam_data_t;
  typedef logic [CAM_IDX_W:0]    cam_cnt_t;

endpackage

// File: rtl/param_cam_if.sv
// Request/response bundle of param_cam.
// master: table user, slave: the CAM. Optional CAM_SEARCH_MASK_EN adds search_mask_i.
interface param_cam_if
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int DATA_W = CAM_DATA_W
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              write_enable_i;
  logic [IDX_W-1:0]  write_index_i;
  logic [DATA_W-1:0] write_data_i;
  logic              invalidate_i;
  logic [IDX_W-1:0]  inv_index_i;
  logic              alloc_i;
  logic              alloc_ack_o;
  logic [IDX_W-1:0]  alloc_index_o;
  logic              read_enable_i;
  logic [IDX_W-1:0]  read_index_i;
  logic [DATA_W-1:0] read_value_o;
  logic              read_valid_o;
  logic              search_enable_i;
  logic [DATA_W-1:0] search_data_i;
`ifdef CAM_SEARCH_MASK_EN
  logic [DATA_W-1:0] search_mask_i;
`endif
  logic              search_done_o;
  logic              search_valid_o;
  logic [IDX_W-1:0]  search_index_o;
  logic              full_o;
  logic [IDX_W:0]    count_o;

  modport master (
    output write_enable_i, write_index_i, write_data_i,
    output invalidate_i, inv_index_i, alloc_i,
    output read_enable_i, read_index_i,
    output search_enable_i, search_data_i,
`ifdef CAM_SEARCH_MASK_EN
    output search_mask_i,
`endif
    input  alloc_ack_o, alloc_index_o,
    input  read_value_o, read_valid_o,
    input  search_done_o, search_valid_o, search_index_o,
    input  full_o, count_o
  );

  modport slave (
    input  write_enable_i, write_index_i, write_data_i,
    input  invalidate_i, inv_index_i, alloc_i,
    input  read_enable_i, read_index_i,
    input  search_enable_i, search_data_i,
`ifdef CAM_SEARCH_MASK_EN
    input  search_mask_i,
`endif
    output alloc_ack_o, alloc_index_o,
    output read_value_o, read_valid_o,
    output search_done_o, search_valid_o, search_index_o,
    output full_o, count_o
  );

endinterface

// File: rtl/cam_lowest_set.sv
// Priority encoder: index of the lowest set bit of vec plus an any-set flag.
// Ports: vec (WIDTH) in, idx ($clog2(WIDTH)) out, hit out; idx is 0 when nothing is set.
module cam_lowest_set #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     hit
);
  localparam int IW = $clog2(WIDTH);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign hit = |vec;

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM: indexed write/invalidate/read, 1-cycle search, free-slot alloc, count/full.
// Ports: clk_i, rst_i (sync, active-high), cam (param_cam_if.slave); CAM_SEARCH_MASK_EN adds a search mask.
module param_cam
  import cam_pkg::*;
#(
  parameter int DEPTH  = CAM_DEPTH,
  parameter int DATA_W = CAM_DATA_W
) (
  input logic        clk_i,
  input logic        rst_i,
  param_cam_if.slave cam
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  match;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] cmp_mask;

  logic [IDX_W-1:0]  hit_idx;
  logic              hit_any;
  logic [IDX_W-1:0]  free_idx;
  logic              free_any;
  logic              alloc_go;

  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  count_q;
  logic              full_q;

  logic              ack_q;
  logic [IDX_W-1:0]  aidx_q;
  logic [DATA_W-1:0] rval_q;
  logic              rvld_q;
  logic              sdone_q;
  logic              svld_q;
  logic [IDX_W-1:0]  sidx_q;

`ifdef CAM_SEARCH_MASK_EN
  assign cmp_mask = cam.search_mask_i;
`else
  assign cmp_mask = '1;
`endif

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &&
        (((data_q[i] ^ cam.search_data_i) & cmp_mask) == '0);
    end
  end

  cam_lowest_set #(.WIDTH(DEPTH)) u_match (
    .vec (match),
    .idx (hit_idx),
    .hit (hit_any)
  );

  cam_lowest_set #(.WIDTH(DEPTH)) u_free (
    .vec (~valid_q),
    .idx (free_idx),
    .hit (free_any)
  );

  // free_idx is taken from pre-edge valid bits, so an
  // invalidate in the same cycle cannot feed the allocator.
  assign alloc_go = cam.alloc_i & ~cam.write_enable_i & free_any;

  // Order matters: a write to the invalidated index wins.
  always_comb begin
    valid_d = valid_q;
    if (cam.invalidate_i) valid_d[cam.inv_index_i] = 1'b0;
    if (cam.write_enable_i) valid_d[cam.write_index_i] = 1'b1;
    if (alloc_go) valid_d[free_idx] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      aidx_q  <= '0;
      rval_q  <= '0;
      rvld_q  <= 1'b0;
      sdone_q <= 1'b0;
      svld_q  <= 1'b0;
      sidx_q  <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= cnt_d;
      full_q  <= &valid_d;
      ack_q   <= alloc_go;
      if (alloc_go) aidx_q <= free_idx;
      if (cam.read_enable_i) begin
        rval_q <= data_q[cam.read_index_i];
        rvld_q <= valid_q[cam.read_index_i];
      end
      sdone_q <= cam.search_enable_i;
      if (cam.search_enable_i) begin
        svld_q <= hit_any;
        sidx_q <= hit_idx;
      end
    end
  end

  // Data array has no reset; only the valid bits are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (cam.write_enable_i) begin
        data_q[cam.write_index_i] <= cam.write_data_i;
      end else if (alloc_go) begin
        data_q[free_idx] <= cam.write_data_i;
      end
    end
  end

  assign cam.alloc_ack_o    = ack_q;
  assign cam.alloc_index_o  = aidx_q;
  assign cam.read_value_o   = rval_q;
  assign cam.read_valid_o   = rvld_q;
  assign cam.search_done_o  = sdone_q;
  assign cam.search_valid_o = svld_q;
  assign cam.search_index_o = sidx_q;
  assign cam.full_o         = full_q;
  assign cam.count_o        = count_q;

endmodule

// File: tb/tb_param_cam.sv
// Directed bench for param_cam with a reference model and result queues.
// Covers search, alloc, read, invalidate, reset and the optional mask.
module tb_param_cam;
  import cam_pkg::*;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_cam_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) cif ();

  param_cam #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cam   (cif)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } sres_t;

  typedef struct packed {
    logic              v;
    logic              known;
    logic [DATA_W-1:0] d;
  } rres_t;

  typedef struct packed {
    logic             ack;
    logic [IDX_W-1:0] idx;
  } ares_t;

  sres_t sq[$];
  rres_t rq[$];
  ares_t aq[$];

  logic              mv [DEPTH];
  logic              mk [DEPTH];
  logic [DATA_W-1:0] md [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (mv[i]) c++;
    return c;
  endfunction

  task automatic idle();
    cif.write_enable_i  = 1'b0;
    cif.write_index_i   = '0;
    cif.write_data_i    = '0;
    cif.invalidate_i    = 1'b0;
    cif.inv_index_i     = '0;
    cif.alloc_i         = 1'b0;
    cif.read_enable_i   = 1'b0;
    cif.read_index_i    = '0;
    cif.search_enable_i = 1'b0;
    cif.search_data_i   = '0;
`ifdef CAM_SEARCH_MASK_EN
    cif.search_mask_i   = '1;
`endif
  endtask

  // One clock: push expectations from the model, advance, pop and compare.
  task automatic tick();
    logic s_req, r_req, a_req, rs;
    sres_t s;
    rres_t r;
    ares_t a;
    logic [DATA_W-1:0] msk;
    s_req = 1'b0;
    r_req = 1'b0;
    a_req = 1'b0;
    s = '0;
    r = '0;
    a = '0;
    rs = rst;
`ifdef CAM_SEARCH_MASK_EN
    msk = cif.search_mask_i;
`else
    msk = '1;
`endif
    if (rs) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    end else begin
      s_req = cif.search_enable_i;
      r_req = cif.read_enable_i;
      a_req = cif.alloc_i;
      if (s_req) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (mv[i] && (((md[i] ^ cif.search_data_i) & msk) == '0)) begin
            s.v = 1'b1;
            s.idx = IDX_W'(i);
          end
        end
        sq.push_back(s);
      end
      if (r_req) begin
        r.v = mv[cif.read_index_i];
        r.known = mk[cif.read_index_i];
        r.d = md[cif.read_index_i];
        rq.push_back(r);
      end
      if (a_req) begin
        if (!cif.write_enable_i && mcount() < DEPTH) begin
          a.ack = 1'b1;
          for (int i = DEPTH - 1; i >= 0; i--) if (!mv[i]) a.idx = IDX_W'(i);
        end
        aq.push_back(a);
      end
      if (cif.invalidate_i) mv[cif.inv_index_i] = 1'b0;
      if (cif.write_enable_i) begin
        mv[cif.write_index_i] = 1'b1;
        mk[cif.write_index_i] = 1'b1;
        md[cif.write_index_i] = cif.write_data_i;
      end
      if (a.ack) begin
        mv[a.idx] = 1'b1;
        mk[a.idx] = 1'b1;
        md[a.idx] = cif.write_data_i;
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      chk("rst_ack", 64'(cif.alloc_ack_o), 64'(0));
      chk("rst_aidx", 64'(cif.alloc_index_o), 64'(0));
      chk("rst_rval", 64'(cif.read_value_o), 64'(0));
      chk("rst_rvld", 64'(cif.read_valid_o), 64'(0));
      chk("rst_sdone", 64'(cif.search_done_o), 64'(0));
      chk("rst_svld", 64'(cif.search_valid_o), 64'(0));
      chk("rst_sidx", 64'(cif.search_index_o), 64'(0));
    end else begin
      chk("search_done", 64'(cif.search_done_o), 64'(s_req));
      if (s_req) begin
        s = sq.pop_front();
        chk("search_valid", 64'(cif.search_valid_o), 64'(s.v));
        chk("search_index", 64'(cif.search_index_o), 64'(s.idx));
      end
      if (r_req) begin
        r = rq.pop_front();
        chk("read_valid", 64'(cif.read_valid_o), 64'(r.v));
        if (r.known) chk("read_value", 64'(cif.read_value_o), 64'(r.d));
      end
      if (a_req) a = aq.pop_front();
      chk("alloc_ack", 64'(cif.alloc_ack_o), 64'(a.ack));
      if (a.ack) chk("alloc_index", 64'(cif.alloc_index_o), 64'(a.idx));
    end
    chk("count", 64'(cif.count_o), 64'(mcount()));
    chk("full", 64'(cif.full_o), 64'(mcount() == DEPTH));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [DATA_W-1:0] d);
    idle();
    cif.write_enable_i = 1'b1;
    cif.write_index_i  = IDX_W'(idx);
    cif.write_data_i   = d;
    tick();
  endtask

  task automatic srch(input logic [DATA_W-1:0] d);
    idle();
    cif.search_enable_i = 1'b1;
    cif.search_data_i   = d;
    tick();
  endtask

  task automatic rd(input int idx);
    idle();
    cif.read_enable_i = 1'b1;
    cif.read_index_i  = IDX_W'(idx);
    tick();
  endtask

  task automatic inv(input int idx);
    idle();
    cif.invalidate_i = 1'b1;
    cif.inv_index_i  = IDX_W'(idx);
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0;
      mk[i] = 1'b0;
      md[i] = '0;
    end
    idle();

    do_reset();
    chk("reset_count", 64'(cif.count_o), 64'(0));

    wr(5, 32'hDEAD_BEEF);
    srch(32'hDEAD_BEEF);
    chk("tp1_done", 64'(cif.search_done_o), 64'(1));
    chk("tp1_valid", 64'(cif.search_valid_o), 64'(1));
    chk("tp1_index", 64'(cif.search_index_o), 64'(5));
    chk("tp1_count", 64'(cif.count_o), 64'(1));
    idle();
    tick();
    chk("hold_done", 64'(cif.search_done_o), 64'(0));
    chk("hold_valid", 64'(cif.search_valid_o), 64'(1));
    chk("hold_index", 64'(cif.search_index_o), 64'(5));
    srch(32'h5555_5555);
    chk("miss_valid", 64'(cif.search_valid_o), 64'(0));
    chk("miss_index", 64'(cif.search_index_o), 64'(0));

    wr(3, 32'h1234);
    wr(9, 32'h1234);
    srch(32'h1234);
    chk("tp2_low", 64'(cif.search_index_o), 64'(3));
    inv(3);
    srch(32'h1234);
    chk("tp2_next", 64'(cif.search_index_o), 64'(9));

    do_reset();
    idle();
    cif.write_enable_i  = 1'b1;
    cif.write_index_i   = IDX_W'(7);
    cif.write_data_i    = 32'hAA;
    cif.search_enable_i = 1'b1;
    cif.search_data_i   = 32'hAA;
    tick();
    chk("tp3_same", 64'(cif.search_valid_o), 64'(0));
    srch(32'hAA);
    chk("tp3_next_v", 64'(cif.search_valid_o), 64'(1));
    chk("tp3_next_i", 64'(cif.search_index_o), 64'(7));

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      cif.alloc_i = 1'b1;
      cif.write_data_i = DATA_W'(i);
      tick();
      chk("tp4_idx", 64'(cif.alloc_index_o), 64'(i));
    end
    chk("tp4_full", 64'(cif.full_o), 64'(1));
    chk("tp4_count", 64'(cif.count_o), 64'(DEPTH));
    idle();
    cif.alloc_i = 1'b1;
    cif.write_data_i = 32'h99;
    tick();
    chk("tp4_ovf_ack", 64'(cif.alloc_ack_o), 64'(0));
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      chk("tp4_keep", 64'(cif.read_value_o), 64'(i));
    end

    idle();
    cif.write_enable_i = 1'b1;
    cif.write_index_i  = IDX_W'(4);
    cif.write_data_i   = 32'h44;
    cif.invalidate_i   = 1'b1;
    cif.inv_index_i    = IDX_W'(4);
    tick();
    rd(4);
    chk("tp5_wins", 64'(cif.read_valid_o), 64'(1));
    chk("tp5_cnt32", 64'(cif.count_o), 64'(32));
    inv(4);
    rd(4);
    chk("tp5_inv", 64'(cif.read_valid_o), 64'(0));
    chk("tp5_cnt31", 64'(cif.count_o), 64'(31));
    idle();
    cif.alloc_i        = 1'b1;
    cif.write_enable_i = 1'b1;
    cif.write_index_i  = IDX_W'(4);
    cif.write_data_i   = 32'h45;
    tick();
    chk("alloc_vs_wr", 64'(cif.alloc_ack_o), 64'(0));
    idle();
    cif.alloc_i      = 1'b1;
    cif.invalidate_i = 1'b1;
    cif.inv_index_i  = IDX_W'(4);
    tick();
    chk("alloc_inv_ack", 64'(cif.alloc_ack_o), 64'(0));
    idle();
    cif.alloc_i = 1'b1;
    cif.write_data_i = 32'h77;
    tick();
    chk("alloc_reuse", 64'(cif.alloc_index_o), 64'(4));

    do_reset();
    for (int j = 0; j < 10; j++) wr(j, 32'h100 + DATA_W'(j));
    idle();
    cif.write_enable_i = 1'b1;
    cif.write_index_i  = '0;
    cif.write_data_i   = 32'hBAD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tp6_count", 64'(cif.count_o), 64'(0));
    for (int j = 0; j < 10; j++) srch(32'h100 + DATA_W'(j));
    srch(32'hBAD);
    for (int j = 0; j < 10; j++) rd(j);
    chk("tp6_rvld", 64'(cif.read_valid_o), 64'(0));

`ifdef CAM_SEARCH_MASK_EN
    wr(2, 32'hFF00);
    idle();
    cif.search_enable_i = 1'b1;
    cif.search_data_i   = 32'h0F00;
    cif.search_mask_i   = 32'h0F00;
    tick();
    chk("mask_hit", 64'(cif.search_valid_o), 64'(1));
    chk("mask_idx", 64'(cif.search_index_o), 64'(2));
    idle();
    cif.search_enable_i = 1'b1;
    cif.search_data_i   = 32'h1234_5678;
    cif.search_mask_i   = '0;
    tick();
    chk("mask_zero", 64'(cif.search_valid_o), 64'(1));
`endif

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
